// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
module pc_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] ld_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    if (ld) begin
      pc_d = ld_addr;
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: owns the PC, drives imem address, registers IF/ID.
// Optional feature macro FETCH_WRAP_EN: wrap PC to 0 after the last word
// instead of halting.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             if_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [31:0] END_ADDR = 32'(MEM_WORDS * 4);

  fetch_state_e     state_q, state_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic             if_valid_q, if_valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic             pc_ld;
  logic             pc_inc;
  logic [31:0]      pc_ld_addr;

  pc_reg u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .ld      (pc_ld),
    .ld_addr (pc_ld_addr),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign pc_next   = pc + PC_STEP;
  assign imem_addr = pc;

  // Next-state, PC control and IF/ID updates.
  always_comb begin
    state_d    = state_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld_addr = '0;

    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_ld      = 1'b1;
          pc_ld_addr = branch_addr & ~32'h3;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
        end else if (freeze) begin
          // hazard stall: everything holds
        end else if (pc >= END_ADDR) begin
          // out-of-range target: stop without fetching
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else begin
          if_instr_d = imem_data;
          if_pc_d    = pc_next;
          if_valid_d = 1'b1;
          cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (pc_next == END_ADDR) begin
`ifdef FETCH_WRAP_EN
            pc_ld      = 1'b1;
            pc_ld_addr = '0;
`else
            pc_inc     = 1'b1;
            state_d    = HALT;
`endif
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
        if (branch_taken) begin
          state_d    = RUN;
          pc_ld      = 1'b1;
          pc_ld_addr = branch_addr & ~32'h3;
          if_instr_d = NOP_INSTR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  // FSM and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;
  assign halted    = halted_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (16-bit and 4-bit counters).
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [31:0] imem_addr4;
  logic [31:0] imem_data4;
  logic [31:0] if_pc4;
  logic [31:0] if_instr4;
  logic        if_valid4;
  logic        halted4;
  logic [3:0]  fetch_cnt4;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  // Instruction memory contents: tagged word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | {2'b00, a[31:2]};
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_data4 = mem_word(imem_addr4);

  fetch_sequencer #(.MEM_WORDS(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .halted       (halted),
    .fetch_cnt    (fetch_cnt)
  );

  fetch_sequencer #(.MEM_WORDS(32), .CNT_W(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr4),
    .imem_data    (imem_data4),
    .if_pc        (if_pc4),
    .if_instr     (if_instr4),
    .if_valid     (if_valid4),
    .halted       (halted4),
    .fetch_cnt    (fetch_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat4(input int c);
    return (c > 15) ? 32'd15 : 32'(c);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},     imem_addr, 32'h0);
    chk({tag, "_ifpc"},   if_pc, 32'h0);
    chk({tag, "_instr"},  if_instr, 32'h0);
    chk({tag, "_valid"},  32'(if_valid), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_cnt"},    32'(fetch_cnt), 32'h0);
    chk({tag, "_cnt4"},   32'(fetch_cnt4), 32'h0);
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    #2;
    chk_reset("rst0");
    step();
    step();
    chk_reset("rst1");

    // release; first edge is the IDLE cycle
    rst = 1'b1;
    step();
    chk("idle_pc", imem_addr, 32'h0);
    chk("idle_valid", 32'(if_valid), 32'h0);
    chk("idle_cnt", 32'(fetch_cnt), 32'h0);

    // first fetch at 0
    step();
    exp_cnt = 1;
    chk("f0_pc", imem_addr, 32'h4);
    chk("f0_ifpc", if_pc, 32'h4);
    chk("f0_instr", if_instr, mem_word(32'h0));
    chk("f0_valid", 32'(if_valid), 32'h1);
    chk("f0_cnt", 32'(fetch_cnt), 32'd1);

    // three more fetches: 4, 8, 12
    for (int i = 1; i < 4; i++) begin
      step();
      exp_cnt++;
      chk("seq_pc", imem_addr, 32'(4 * (i + 1)));
      chk("seq_cnt", 32'(fetch_cnt), 32'(exp_cnt));
      chk("seq_instr", if_instr, mem_word(32'(4 * i)));
    end

    // freeze for 3 cycles at pc 0x10
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_pc", imem_addr, 32'h10);
      chk("frz_ifpc", if_pc, 32'h10);
      chk("frz_instr", if_instr, mem_word(32'hC));
      chk("frz_cnt", 32'(fetch_cnt), 32'd4);
    end
    freeze = 1'b0;
    step();
    exp_cnt = 5;
    chk("resume_instr", if_instr, mem_word(32'h10));
    chk("resume_ifpc", if_pc, 32'h14);
    chk("resume_cnt", 32'(fetch_cnt), 32'd5);

    // branch beats freeze; unaligned target
    branch_taken = 1'b1;
    branch_addr  = 32'h2B;
    freeze       = 1'b1;
    step();
    chk("br_pc", imem_addr, 32'h28);
    chk("br_valid", 32'(if_valid), 32'h0);
    chk("br_instr", if_instr, 32'h0);
    chk("br_ifpc", if_pc, 32'h14);
    chk("br_cnt", 32'(fetch_cnt), 32'd5);
    branch_taken = 1'b0;
    freeze       = 1'b0;
    step();
    exp_cnt = 6;
    chk("br_fetch_instr", if_instr, mem_word(32'h28));
    chk("br_fetch_ifpc", if_pc, 32'h2C);
    chk("br_fetch_cnt", 32'(fetch_cnt), 32'd6);

    // run to the last word
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt++;
    end
    chk("last_pc", imem_addr, 32'h7C);
    chk("last_cnt", 32'(fetch_cnt), 32'd26);
    chk("sat_cnt4", 32'(fetch_cnt4), 32'd15);

    step();
    exp_cnt = 27;
    chk("end_instr", if_instr, mem_word(32'h7C));
    chk("end_ifpc", if_pc, 32'h80);
    chk("end_valid", 32'(if_valid), 32'h1);
    chk("end_cnt", 32'(fetch_cnt), 32'd27);
`ifdef FETCH_WRAP_EN
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_halted", 32'(halted), 32'h0);
    step();
    exp_cnt++;
    chk("wrap_instr", if_instr, mem_word(32'h0));
    chk("wrap_pc2", imem_addr, 32'h4);
    chk("wrap_halted2", 32'(halted), 32'h0);
`else
    chk("halt_pc", imem_addr, 32'h80);
    chk("halt_halted", 32'(halted), 32'h1);
    freeze = 1'b1;
    step();
    chk("halt_valid", 32'(if_valid), 32'h0);
    chk("halt_halted2", 32'(halted), 32'h1);
    chk("halt_pc2", imem_addr, 32'h80);
    chk("halt_cnt", 32'(fetch_cnt), 32'd27);
    freeze = 1'b0;
`endif

    // branch to 0 and fetch
    branch_taken = 1'b1;
    branch_addr  = 32'h0;
    step();
    chk("rb_halted", 32'(halted), 32'h0);
    chk("rb_pc", imem_addr, 32'h0);
    chk("rb_valid", 32'(if_valid), 32'h0);
    branch_taken = 1'b0;
    step();
    exp_cnt++;
    chk("rb_instr", if_instr, mem_word(32'h0));
    chk("rb_cnt", 32'(fetch_cnt), 32'(exp_cnt));

    // out-of-range branch target halts without a fetch
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    chk("oor_pc", imem_addr, 32'h100);
    branch_taken = 1'b0;
    step();
    chk("oor_halted", 32'(halted), 32'h1);
    chk("oor_pc2", imem_addr, 32'h100);
    chk("oor_valid", 32'(if_valid), 32'h0);
    chk("oor_cnt", 32'(fetch_cnt), 32'(exp_cnt));

    // leave HALT toward 0x38, then fetch up to pc 0x40
    branch_taken = 1'b1;
    branch_addr  = 32'h38;
    step();
    chk("oor_exit_halted", 32'(halted), 32'h0);
    chk("oor_exit_pc", imem_addr, 32'h38);
    branch_taken = 1'b0;
    step();
    step();
    exp_cnt += 2;
    chk("pre_rst_pc", imem_addr, 32'h40);
    chk("pre_rst_cnt", 32'(fetch_cnt), 32'(exp_cnt));
    chk("pre_rst_cnt4", 32'(fetch_cnt4), sat4(exp_cnt));
    chk("pre_rst_valid", 32'(if_valid), 32'h1);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async");
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_rst_pc", imem_addr, 32'h4);
    chk("post_rst_cnt", 32'(fetch_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
